// File: rtl/snitch_shared_acc_arbiter.sv
// snitch_shared_acc_arbiter
//
// Shares one tile-level offload accelerator (MUL/DIV/REM) among NumCores
// Snitch cores. A round-robin arbiter picks one requester per cycle and tags
// the request with the requester's hart index. Outstanding requests are
// bounded by MaxOutstanding. Responses are routed back to a core by hart_id.
//
// Optional feature macro: SNITCH_SH_ACC_SPILL_EN
//   defined     - a two-entry spill register sits between the arbiter and
//                 acc_req_o. Requests appear 1 cycle later, and the
//                 throughput stays one request per cycle.
//   not defined - the request path is combinational.
//
// Handshakes: a transfer happens in a cycle where valid and ready are both 1.
// Valid never depends on ready. After a source raises valid, it holds valid
// and the payload stable until the transfer.
//
// Ports
//   clk_i, rst_ni       clock; asynchronous active-low reset
//   core_req_i          NumCores x request payload, ReqW bits each:
//                       {addr[31:0], id[4:0], data_op[31:0],
//                        data_arga[31:0], data_argb[31:0], data_argc[31:0]}
//   core_req_valid_i    per-core request valid
//   core_req_ready_o    per-core request ready (one-hot, only on transfer)
//   core_resp_o         NumCores x response, RespW bits each:
//                       {write, error, id[4:0], data[31:0]}
//   core_resp_valid_o   per-core response valid
//   core_resp_ready_i   per-core response ready
//   acc_req_o           granted payload, passed through unmodified
//   acc_req_hart_o      index of the granted core
//   acc_req_valid_o     accelerator request valid
//   acc_req_ready_i     accelerator request ready
//   acc_resp_i          accelerator response, AccRespW bits:
//                       {hart_id[5:0], error, id[4:0], data[31:0]}
//   acc_resp_valid_i    accelerator response valid
//   acc_resp_ready_o    accelerator response ready
//   outstanding_o       in-flight request count
//   route_err_o         sticky error: illegal hart_id or counter underflow
module snitch_shared_acc_arbiter #(
    parameter int unsigned NumCores       = 4,
    parameter int unsigned MaxOutstanding = 2,
    localparam int unsigned ReqW          = 165,
    localparam int unsigned RespW         = 39,
    localparam int unsigned AccRespW      = 44
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NumCores*ReqW-1:0]  core_req_i,
    input  logic [NumCores-1:0]       core_req_valid_i,
    output logic [NumCores-1:0]       core_req_ready_o,
    output logic [NumCores*RespW-1:0] core_resp_o,
    output logic [NumCores-1:0]       core_resp_valid_o,
    input  logic [NumCores-1:0]       core_resp_ready_i,
    output logic [ReqW-1:0]           acc_req_o,
    output logic [5:0]                acc_req_hart_o,
    output logic                      acc_req_valid_o,
    input  logic                      acc_req_ready_i,
    input  logic [AccRespW-1:0]       acc_resp_i,
    input  logic                      acc_resp_valid_i,
    output logic                      acc_resp_ready_o,
    output logic [3:0]                outstanding_o,
    output logic                      route_err_o
);

    localparam int unsigned PtrW = $clog2(NumCores);

    logic [PtrW-1:0] r_ptr;
    logic            r_lock;
    logic [PtrW-1:0] r_lock_idx;
    logic [3:0]      r_outstanding;
    logic            r_route_err;

    logic [PtrW-1:0] w_rr_idx;
    logic [PtrW-1:0] w_grant;
    logic            w_found;
    int unsigned     w_idx;
    logic            w_stall;
    logic            w_arb_valid;
    logic            w_arb_ready;
    logic            w_req_hs;
    logic            w_resp_hs;
    logic [ReqW-1:0] w_arb_data;
    logic [5:0]      w_resp_hart;
    logic            w_hart_ok;

    // Round-robin pick: the first valid core at or after r_ptr, with wrap-around.
    always_comb begin
        w_rr_idx = r_ptr;
        w_found  = 1'b0;
        w_idx    = 0;
        for (int unsigned k = 0; k < NumCores; k++) begin
            w_idx = k + 32'(r_ptr);
            if (w_idx >= NumCores) w_idx = w_idx - NumCores;
            if (!w_found && core_req_valid_i[w_idx]) begin
                w_found  = 1'b1;
                w_rr_idx = w_idx[PtrW-1:0];
            end
        end
    end

    // A request that was offered and not accepted keeps its grant, so a
    // higher-priority core that becomes valid later cannot preempt it.
    assign w_grant     = r_lock ? r_lock_idx : w_rr_idx;
    // The stall uses only the registered count. A response in the same
    // cycle frees the credit from the next cycle on.
    assign w_stall     = (r_outstanding == 4'(MaxOutstanding));
    assign w_arb_valid = rst_ni & core_req_valid_i[w_grant] & ~w_stall;
    assign w_arb_data  = core_req_i[32'(w_grant)*ReqW +: ReqW];
    assign w_req_hs    = w_arb_valid & w_arb_ready;

    always_comb begin
        core_req_ready_o = '0;
        if (w_req_hs) core_req_ready_o[w_grant] = 1'b1;
    end

`ifdef SNITCH_SH_ACC_SPILL_EN
    // Two-entry spill register. Ready depends only on the fill level, so
    // the arbiter side sees no combinational path from acc_req_ready_i.
    logic [ReqW+5:0] r_sp_mem [2];
    logic            r_sp_wr;
    logic            r_sp_rd;
    logic [1:0]      r_sp_cnt;
    logic            w_sp_pop;
    logic [ReqW+5:0] w_sp_head;

    assign w_arb_ready     = (r_sp_cnt != 2'd2);
    assign w_sp_head       = r_sp_mem[r_sp_rd];
    assign acc_req_valid_o = rst_ni & (r_sp_cnt != 2'd0);
    assign w_sp_pop        = acc_req_valid_o & acc_req_ready_i;
    assign acc_req_o       = w_sp_head[ReqW-1:0];
    assign acc_req_hart_o  = w_sp_head[ReqW+5:ReqW];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sp_mem[0] <= '0;
            r_sp_mem[1] <= '0;
            r_sp_wr     <= 1'b0;
            r_sp_rd     <= 1'b0;
            r_sp_cnt    <= 2'd0;
        end else begin
            if (w_req_hs) begin
                r_sp_mem[r_sp_wr] <= {6'(w_grant), w_arb_data};
                r_sp_wr           <= ~r_sp_wr;
            end
            if (w_sp_pop) r_sp_rd <= ~r_sp_rd;
            if (w_req_hs && !w_sp_pop)      r_sp_cnt <= r_sp_cnt + 2'd1;
            else if (!w_req_hs && w_sp_pop) r_sp_cnt <= r_sp_cnt - 2'd1;
        end
    end
`else
    assign w_arb_ready     = acc_req_ready_i;
    assign acc_req_valid_o = w_arb_valid;
    assign acc_req_o       = w_arb_data;
    assign acc_req_hart_o  = 6'(w_grant);
`endif

    // Response routing. An illegal hart_id is accepted and dropped, so the
    // accelerator can never stall on it.
    assign w_resp_hart = acc_resp_i[43:38];
    assign w_hart_ok   = (32'(w_resp_hart) < NumCores);

    always_comb begin
        core_resp_valid_o = '0;
        core_resp_o       = '0;
        acc_resp_ready_o  = 1'b0;
        if (rst_ni) begin
            if (!w_hart_ok) begin
                acc_resp_ready_o = 1'b1;
            end else begin
                for (int unsigned i = 0; i < NumCores; i++) begin
                    if (w_resp_hart == 6'(i)) begin
                        core_resp_valid_o[i]          = acc_resp_valid_i;
                        core_resp_o[i*RespW +: RespW] = {1'b1, acc_resp_i[37:0]};
                        acc_resp_ready_o              = core_resp_ready_i[i];
                    end
                end
            end
        end
    end

    assign w_resp_hs = acc_resp_valid_i & acc_resp_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr         <= '0;
            r_lock        <= 1'b0;
            r_lock_idx    <= '0;
            r_outstanding <= 4'd0;
            r_route_err   <= 1'b0;
        end else begin
            if (w_req_hs) begin
                r_ptr <= (w_grant == PtrW'(NumCores - 1)) ? '0 : w_grant + 1'b1;
            end
            r_lock     <= w_arb_valid & ~w_arb_ready;
            r_lock_idx <= w_grant;
            // A response with nothing in flight saturates at zero.
            if (w_req_hs && !w_resp_hs) begin
                r_outstanding <= r_outstanding + 4'd1;
            end else if (!w_req_hs && w_resp_hs && r_outstanding != 4'd0) begin
                r_outstanding <= r_outstanding - 4'd1;
            end
            if (w_resp_hs && (!w_hart_ok || r_outstanding == 4'd0)) begin
                r_route_err <= 1'b1;
            end
        end
    end

    assign outstanding_o = r_outstanding;
    assign route_err_o   = r_route_err;

endmodule

// File: tb/tb_snitch_shared_acc_arbiter.sv
`timescale 1ns/1ps
module tb_snitch_shared_acc_arbiter;

    localparam int N    = 4;
    localparam int MAXO = 2;
    localparam int RQW  = 165;
    localparam int RSW  = 39;
    localparam int ARW  = 44;
    localparam logic [31:0] OP_MUL = 32'h0200_0033;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [N*RQW-1:0] core_req;
    logic [N-1:0]     core_req_valid, core_req_ready;
    logic [N*RSW-1:0] core_resp;
    logic [N-1:0]     core_resp_valid, core_resp_ready;
    logic [RQW-1:0]   acc_req;
    logic [5:0]       acc_req_hart;
    logic             acc_req_valid, acc_req_ready;
    logic [ARW-1:0]   acc_resp;
    logic             acc_resp_valid, acc_resp_ready;
    logic [3:0]       outstanding;
    logic             route_err;

    snitch_shared_acc_arbiter #(.NumCores(N), .MaxOutstanding(MAXO)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .core_req_i        (core_req),
        .core_req_valid_i  (core_req_valid),
        .core_req_ready_o  (core_req_ready),
        .core_resp_o       (core_resp),
        .core_resp_valid_o (core_resp_valid),
        .core_resp_ready_i (core_resp_ready),
        .acc_req_o         (acc_req),
        .acc_req_hart_o    (acc_req_hart),
        .acc_req_valid_o   (acc_req_valid),
        .acc_req_ready_i   (acc_req_ready),
        .acc_resp_i        (acc_resp),
        .acc_resp_valid_i  (acc_resp_valid),
        .acc_resp_ready_o  (acc_resp_ready),
        .outstanding_o     (outstanding),
        .route_err_o       (route_err)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int n_vec = 0;
    int n_bad = 0;
    logic [3:0] exp_q[$];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [RQW-1:0] mk_req(input logic [31:0] addr, input logic [4:0] id,
                                              input logic [31:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] c);
        return {addr, id, op, a, b, c};
    endfunction

    // ---------------- behavioural model ----------------
    int   m_ptr, m_out, m_lock_g, m_sp_n;
    logic m_err, m_lock;
    logic [RQW+5:0] m_sp0, m_sp1;

    int             e_g, e_h;
    logic           e_arb_valid, e_arb_ready, e_hs, e_acc_valid, e_acc_resp_ready;
    logic           e_dec, e_legal, e_pop;
    logic [RQW-1:0] e_acc_req;
    logic [5:0]     e_acc_hart;
    logic [N-1:0]   e_core_ready, e_resp_valid;
    logic [N*RSW-1:0] e_core_resp;
    logic [RQW+5:0] e_item;

    always_comb begin
        e_g = m_ptr;
        if (m_lock) begin
            e_g = m_lock_g;
        end else begin
            // scanning from the far end leaves the nearest valid core
            for (int k = N - 1; k >= 0; k--) begin
                if (core_req_valid[(m_ptr + k) % N]) e_g = (m_ptr + k) % N;
            end
        end
        e_arb_valid = rst_n && core_req_valid[e_g] && (m_out < MAXO);
        e_item      = {6'(e_g), core_req[e_g*RQW +: RQW]};
`ifdef SNITCH_SH_ACC_SPILL_EN
        e_arb_ready = (m_sp_n < 2);
        e_acc_valid = rst_n && (m_sp_n > 0);
        e_acc_req   = m_sp0[RQW-1:0];
        e_acc_hart  = m_sp0[RQW+5:RQW];
`else
        e_arb_ready = acc_req_ready;
        e_acc_valid = e_arb_valid;
        e_acc_req   = e_item[RQW-1:0];
        e_acc_hart  = e_item[RQW+5:RQW];
`endif
        e_pop        = e_acc_valid && acc_req_ready;
        e_hs         = e_arb_valid && e_arb_ready;
        e_core_ready = '0;
        if (e_hs) e_core_ready[e_g] = 1'b1;

        e_h              = int'(acc_resp[43:38]);
        e_legal          = (e_h < N);
        e_resp_valid     = '0;
        e_core_resp      = '0;
        e_acc_resp_ready = 1'b0;
        if (rst_n) begin
            if (e_legal) begin
                e_resp_valid[e_h]            = acc_resp_valid;
                e_core_resp[e_h*RSW +: RSW]  = {1'b1, acc_resp[37:0]};
                e_acc_resp_ready             = core_resp_ready[e_h];
            end else begin
                e_acc_resp_ready = 1'b1;
            end
        end
        e_dec = acc_resp_valid && e_acc_resp_ready;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ptr    <= 0;
            m_out    <= 0;
            m_err    <= 1'b0;
            m_lock   <= 1'b0;
            m_lock_g <= 0;
            m_sp_n   <= 0;
            m_sp0    <= '0;
            m_sp1    <= '0;
        end else begin
            if (e_hs) m_ptr <= (e_g + 1) % N;
            if (e_hs && !e_dec)                   m_out <= m_out + 1;
            else if (!e_hs && e_dec && m_out > 0) m_out <= m_out - 1;
            if (e_dec && (!e_legal || m_out == 0)) m_err <= 1'b1;
            m_lock   <= e_arb_valid && !e_arb_ready;
            m_lock_g <= e_g;
`ifdef SNITCH_SH_ACC_SPILL_EN
            // queue kept with its head at slot 0
            if (e_pop) m_sp0 <= (e_hs && m_sp_n == 1) ? e_item : m_sp1;
            else if (e_hs && m_sp_n == 0) m_sp0 <= e_item;
            if (e_hs && (m_sp_n - (e_pop ? 1 : 0)) == 1) m_sp1 <= e_item;
            m_sp_n <= m_sp_n + (e_hs ? 1 : 0) - (e_pop ? 1 : 0);
`endif
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("acc_req_valid", 256'(acc_req_valid), 256'(e_acc_valid));
        if (e_acc_valid) begin
            check("acc_req", 256'(acc_req), 256'(e_acc_req));
            check("acc_req_hart", 256'(acc_req_hart), 256'(e_acc_hart));
        end
        check("core_req_ready", 256'(core_req_ready), 256'(e_core_ready));
        check("core_resp_valid", 256'(core_resp_valid), 256'(e_resp_valid));
        check("core_resp", 256'(core_resp), 256'(e_core_resp));
        check("acc_resp_ready", 256'(acc_resp_ready), 256'(e_acc_resp_ready));
        check("outstanding", 256'(outstanding), 256'(m_out));
        check("route_err", 256'(route_err), 256'(m_err));
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // ---------------- directed stimulus ----------------
    logic [RQW-1:0] p1, p2;
    logic [3:0]     g;

    initial begin
        rst_n           = 1'b0;
        core_req        = '0;
        core_req_valid  = '1;
        core_resp_ready = '1;
        acc_req_ready   = 1'b1;
        acc_resp        = {6'd0, 1'b0, 5'd0, 32'd0};
        acc_resp_valid  = 1'b1;
        for (int i = 0; i < N; i++) begin
            core_req[i*RQW +: RQW] = mk_req(32'h1000 + 32'(i), 5'(i), OP_MUL,
                                            32'(i + 1), 32'(i + 2), 32'd0);
        end
        p1 = core_req[1*RQW +: RQW];

        // reset: every output quiet even with valid inputs present
        at_neg();
        at_neg();
        check("rst_outstanding", 256'(outstanding), 256'd0);
        check("rst_route_err", 256'(route_err), 256'd0);
        check("rst_acc_req_valid", 256'(acc_req_valid), 256'd0);
        check("rst_core_req_ready", 256'(core_req_ready), 256'd0);
        check("rst_core_resp_valid", 256'(core_resp_valid), 256'd0);
        check("rst_acc_resp_ready", 256'(acc_resp_ready), 256'd0);
        tick();
        core_req_valid = '0;
        acc_resp_valid = 1'b0;
        rst_n          = 1'b1;

        // single requester: core 2, id 5, MUL 7 x 6
        p2 = mk_req(32'h2000, 5'd5, OP_MUL, 32'd7, 32'd6, 32'd0);
        core_req[2*RQW +: RQW] = p2;
        core_req_valid = 4'b0100;
        at_neg();
        check("single_ready", 256'(core_req_ready), 256'(4'b0100));
        check("single_out0", 256'(outstanding), 256'd0);
`ifndef SNITCH_SH_ACC_SPILL_EN
        check("single_hart", 256'(acc_req_hart), 256'd2);
        check("single_payload", 256'(acc_req), 256'(p2));
`endif
        tick();
        core_req_valid = '0;
        at_neg();
        check("single_out1", 256'(outstanding), 256'd1);
`ifdef SNITCH_SH_ACC_SPILL_EN
        check("spill_valid_plus1", 256'(acc_req_valid), 256'd1);
        check("spill_hart", 256'(acc_req_hart), 256'd2);
`else
        check("single_valid_gone", 256'(acc_req_valid), 256'd0);
`endif
        acc_resp       = {6'd2, 1'b0, 5'd5, 32'd42};
        acc_resp_valid = 1'b1;
        at_neg();
        check("single_resp_valid", 256'(core_resp_valid), 256'(4'b0100));
        check("single_resp_data", 256'(core_resp[2*RSW +: RSW]), 256'({1'b1, 1'b0, 5'd5, 32'd42}));
        tick();
        acc_resp_valid = 1'b0;
        at_neg();
        check("single_out_back0", 256'(outstanding), 256'd0);

        // fairness: all cores valid, accelerator always ready
        reset_pulse();
        exp_q.push_back(4'd0);
        exp_q.push_back(4'd1);
        exp_q.push_back(4'd2);
        exp_q.push_back(4'd3);
        exp_q.push_back(4'd0);
        exp_q.push_back(4'd1);
        core_req_valid = '1;
        acc_resp       = {6'd0, 1'b0, 5'd1, 32'd9};
        for (int k = 0; k < 6; k++) begin
            at_neg();
            g = exp_q.pop_front();
            check("fair_grant", 256'(core_req_ready), 256'(4'b0001 << g));
            tick();
            if (k == 0) acc_resp_valid = 1'b1;
        end
        core_req_valid = '0;
        at_neg();
        check("fair_out", 256'(outstanding), 256'd1);
        tick();
        acc_resp_valid = 1'b0;
        at_neg();
        check("fair_out_drain", 256'(outstanding), 256'd0);

        // lock, then credit stall, then simultaneous request and response
        reset_pulse();
        acc_req_ready  = 1'b0;
        core_req_valid = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            at_neg();
`ifndef SNITCH_SH_ACC_SPILL_EN
            check("lock_hart", 256'(acc_req_hart), 256'd1);
            check("lock_payload", 256'(acc_req), 256'(p1));
`endif
            tick();
            if (k == 0) core_req_valid = 4'b0111;
        end
        acc_req_ready = 1'b1;
        at_neg();
`ifndef SNITCH_SH_ACC_SPILL_EN
        check("lock_release", 256'(core_req_ready), 256'(4'b0010));
`endif
        tick();
        core_req_valid = 4'b0101;
        at_neg();
`ifndef SNITCH_SH_ACC_SPILL_EN
        check("lock_next_grant", 256'(core_req_ready), 256'(4'b0100));
`endif
        tick();
        core_req_valid = 4'b0001;
        at_neg();
        check("stall_valid", 256'(acc_req_valid), 256'd0);
        check("stall_ready", 256'(core_req_ready), 256'd0);
        check("stall_out", 256'(outstanding), 256'd2);
        tick();
        acc_resp       = {6'd3, 1'b0, 5'd2, 32'h1234};
        acc_resp_valid = 1'b1;
        at_neg();
        check("stall_same_cycle", 256'(acc_req_valid), 256'd0);
        tick();
        at_neg();
        check("stall_lift_out", 256'(outstanding), 256'd1);
        check("stall_lift_ready", 256'(core_req_ready), 256'(4'b0001));
        tick();
        core_req_valid = '0;
        acc_resp_valid = 1'b0;
        at_neg();
        check("simul_out", 256'(outstanding), 256'd1);

        // illegal hart_id, sticky error, reset mid-flight, underflow
        reset_pulse();
        core_req_valid = 4'b1000;
        at_neg();
        tick();
        core_req_valid  = '0;
        core_resp_ready = '0;
        acc_resp        = {6'd9, 1'b1, 5'd3, 32'hdead};
        acc_resp_valid  = 1'b1;
        at_neg();
        check("err_acc_ready", 256'(acc_resp_ready), 256'd1);
        check("err_no_route", 256'(core_resp_valid), 256'd0);
        check("err_not_yet", 256'(route_err), 256'd0);
        tick();
        acc_resp_valid  = 1'b0;
        core_resp_ready = '1;
        at_neg();
        check("err_set", 256'(route_err), 256'd1);
        check("err_dec", 256'(outstanding), 256'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            at_neg();
            check("err_sticky", 256'(route_err), 256'd1);
        end
        core_req_valid = 4'b0001;
        at_neg();
        tick();
        core_req_valid = '0;
        rst_n          = 1'b0;
        at_neg();
        check("midrst_err", 256'(route_err), 256'd0);
        check("midrst_out", 256'(outstanding), 256'd0);
        tick();
        rst_n          = 1'b1;
        acc_resp       = {6'd1, 1'b0, 5'd7, 32'h55};
        acc_resp_valid = 1'b1;
        at_neg();
        check("uflow_routed", 256'(core_resp_valid), 256'(4'b0010));
        tick();
        acc_resp_valid = 1'b0;
        at_neg();
        check("uflow_err", 256'(route_err), 256'd1);
        check("uflow_out", 256'(outstanding), 256'd0);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
